// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared GPR write-back constants and helpers
package gpr_pkg;

  localparam int GPR_AW       = 5;
  localparam int GPR_DW       = 32;
  localparam int NREQ_DEFAULT = 3;

  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;

  // Pointer/index width; never zero so a single-requester build still elaborates.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// rtl/gpr_wb_arbiter_if.sv - requester bundle and GPR write port of the write-back arbiter
interface gpr_wb_arbiter_if
  import gpr_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int AW   = GPR_AW,
  parameter int DW   = GPR_DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic               gpr_we;
  logic [AW-1:0]      gpr_rd;
  logic [DW-1:0]      gpr_rrd;
  logic               pend_valid;
  logic [AW-1:0]      pend_rd;

  modport master (
    output req_valid, req_rd, req_data,
    input  req_ready, gpr_we, gpr_rd, gpr_rrd, pend_valid, pend_rd
  );

  modport slave (
    input  req_valid, req_rd, req_data,
    output req_ready, gpr_we, gpr_rd, gpr_rrd, pend_valid, pend_rd
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first request at or after ptr, wrapping
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtract is enough to wrap.
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!any && req[pos[PW-1:0]]) begin
        any               = 1'b1;
        gnt[pos[PW-1:0]]  = 1'b1;
        idx               = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - round-robin GPR write-port arbiter with $0 write absorption
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int AW   = GPR_AW,
  parameter int DW   = GPR_DW
) (
  input logic             clk,
  input logic             rst,
  gpr_wb_arbiter_if.slave bus
);

  localparam int PW = ptr_w(NREQ);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] real_req;
  logic [NREQ-1:0] null_req;
  logic [NREQ-1:0] gnt;
  logic            any_gnt;
  logic [AW-1:0]   rd_arr   [NREQ];
  logic [DW-1:0]   data_arr [NREQ];

  logic            we_q;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   data_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign rd_arr[i]   = bus.req_rd[i*AW +: AW];
    assign data_arr[i] = bus.req_data[i*DW +: DW];
    // $0 writes are acked immediately and kept out of arbitration entirely.
    assign null_req[i] = bus.req_valid[i] && (rd_arr[i] == '0);
    assign real_req[i] = bus.req_valid[i] && (rd_arr[i] != '0);
  end

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req (real_req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win_idx),
    .any (any_gnt)
  );

  assign bus.req_ready = gnt | null_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else if (any_gnt) begin
      we_q   <= 1'b1;
      rd_q   <= rd_arr[win_idx];
      data_q <= data_arr[win_idx];
      if (win_idx == PW'(NREQ-1)) ptr <= '0;
      else                        ptr <= win_idx + PW'(1);
    end else begin
      we_q   <= 1'b0;
    end
  end

  assign bus.gpr_we     = we_q;
  assign bus.gpr_rd     = rd_q;
  assign bus.gpr_rrd    = data_q;
  assign bus.pend_valid = we_q;
  assign bus.pend_rd    = rd_q;

endmodule
